bcd_to_bin: RTL and testbench

Sequential BCD-to-binary converter; the inverse of the display-side binary-to-BCD path. Takes a packed multi-digit BCD value (default two digits, e.g. a keypad-entered channel/message number 00–99), runs a reverse double-dabble (shift-right, subtract-3) over 4·DIGITS clock cycles, and returns the binary value with a start/busy/done handshake. Sits between keypad digit capture and the channel/message index logic.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_corr.sv | 11 +
 rtl/bcd_to_bin.sv | 147 ++++++++++++++
 tb/tb_bcd_to_bin.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD-to-binary converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_SUB    = 4'd3;
  localparam logic [3:0] MAX_DIGIT   = 4'd9;

endpackage

// File: rtl/bcd_digit_corr.sv
// rtl/bcd_digit_corr.sv - per-nibble reverse double-dabble correction (>=8 -> -3)
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib_in,
  output logic [DIGIT_W-1:0] nib_out
);

  assign nib_out = (nib_in >= CORR_THRESH) ? (nib_in - CORR_SUB) : nib_in;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter with start/busy/done handshake
// Optional invalid-digit check enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        err
);

  localparam int                BCD_W    = DIGIT_W * DIGITS;
  localparam int                CNT_W    = $clog2(BCD_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BCD_W);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_shift, bcd_corr;
  logic [BCD_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic [BIN_W-1:0]   bin_ext;
  logic               in_bad;
  logic               accept;

  assign accept    = (state_q == IDLE) && start;
  assign bcd_shift = bcd_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .nib_in  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .nib_out (bcd_corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  if (BIN_W > BCD_W) begin : g_zext
    assign bin_ext = {{(BIN_W-BCD_W){1'b0}}, bin_q};
  end else begin : g_trunc
    assign bin_ext = bin_q[BIN_W-1:0];
  end

`ifdef BCD2BIN_CHECK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) in_bad = 1'b1;
    end
  end

  always_comb begin
    bad_d = accept ? in_bad : bad_q;
    err_d = done_d ? bad_q : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign in_bad = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = in_bad ? DONE : SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d    = (state_d == SHIFT);
    done_d    = (state_q == DONE);
    bin_out_d = done_d ? bin_ext : bin_out_q;
  end

  // A rejected input leaves bin_q cleared, so its DONE pass reports zero.
  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = in_bad ? '0 : bcd_in;
          bin_d = '0;
          cnt_d = CNT_LOAD;
        end
      end
      SHIFT: begin
        bcd_d = bcd_corr;
        bin_d = {bcd_q[0], bin_q[BCD_W-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_out_q <= '0;
    end else begin
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_out_q <= bin_out_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin
module tb_bcd_to_bin;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 8;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  int checks;
  int errors;
  logic [BIN_W-1:0] prev_bin;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_bin(input logic [4*DIGITS-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  // inject: pulse start with 0x12 once during SHIFT and once during DONE
  task automatic run_conv(input logic [4*DIGITS-1:0] bcd, input bit inject, input bit invalid);
    int busy_cnt, done_cnt, done_at, lat;
    bit unspec, exp_err;
    logic [BIN_W-1:0] got_bin, exp_bin;
    logic got_err;
    lat = 9; exp_err = 1'b0; unspec = 1'b0;
    exp_bin = BIN_W'(ref_bin(bcd));
`ifdef BCD2BIN_CHECK_EN
    if (invalid) begin lat = 1; exp_err = 1'b1; exp_bin = '0; end
`else
    if (invalid) unspec = 1'b1;
`endif
    busy_cnt = 0; done_cnt = 0; done_at = -1; got_bin = '0; got_err = 1'b0;
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 8'($urandom);
    for (int n = 0; n <= lat + 2; n++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      if (done) begin
        done_cnt++;
        done_at = n;
        got_bin = bin_out;
        got_err = err;
      end
      if (n < lat) check($sformatf("hold_before_done[%0h]", bcd), bin_out, prev_bin);
      if (!exp_err) check($sformatf("err_low[%0h]", bcd), err, 1'b0);
      if (inject) begin
        if (n == 3 || n == 8) begin start = 1'b1; bcd_in = 8'h12; end
        if (n == 4 || n == 9) start = 1'b0;
      end
    end
    check($sformatf("busy_cycles[%0h]", bcd), busy_cnt, (lat == 9) ? 8 : 0);
    check($sformatf("done_count[%0h]", bcd), done_cnt, 1);
    check($sformatf("done_latency[%0h]", bcd), done_at, lat);
    if (!unspec) check($sformatf("bin_out[%0h]", bcd), got_bin, exp_bin);
    check($sformatf("err[%0h]", bcd), got_err, exp_err);
    check($sformatf("hold_after_done[%0h]", bcd), bin_out, got_bin);
    prev_bin = got_bin;
  endtask

  task automatic quiet(input string tag, input int cycles);
    int dcnt, bcnt;
    dcnt = 0; bcnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      dcnt += int'(done);
      bcnt += int'(busy);
    end
    check({tag, "_no_done"}, dcnt, 0);
    check({tag, "_no_busy"}, bcnt, 0);
    check({tag, "_bin_hold"}, bin_out, prev_bin);
  endtask

  initial begin
    logic [3:0] d0, d1;
    checks = 0; errors = 0; prev_bin = '0;
    rst = 1'b0; start = 1'b0; bcd_in = '0;

    #2 rst = 1'b1;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_bin_out", bin_out, 8'h00);
    check("reset_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_conv(8'h99, 1'b0, 1'b0);
    run_conv(8'h00, 1'b0, 1'b0);
    run_conv(8'h10, 1'b0, 1'b0);
    run_conv(8'h47, 1'b0, 1'b0);
    run_conv(8'h01, 1'b0, 1'b0);

    run_conv(8'h25, 1'b1, 1'b0);
    quiet("after_ignored_start", 12);

    @(negedge clk);
    bcd_in = 8'h63;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midshift_rst_busy", busy, 1'b0);
    check("midshift_rst_done", done, 1'b0);
    check("midshift_rst_bin_out", bin_out, 8'h00);
    check("midshift_rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    prev_bin = '0;
    quiet("after_midshift_rst", 12);
    run_conv(8'h07, 1'b0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      d1 = 4'($urandom_range(0, 9));
      d0 = 4'($urandom_range(0, 9));
      run_conv({d1, d0}, 1'b0, 1'b0);
    end

    run_conv(8'h3A, 1'b0, 1'b1);
    run_conv(8'h05, 1'b0, 1'b0);
    run_conv(8'hF0, 1'b0, 1'b1);
    run_conv(8'h99, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
